// File: rtl/e203_exu_longp_wbck_buf.sv
// e203_exu_longp_wbck_buf: in-order long-pipe writeback/exception collector with a one-entry output register
module e203_exu_longp_wbck_buf #(
    parameter int XLEN      = 32,
    parameter int PC_SIZE   = 32,
    parameter int ADDR_SIZE = 32,
    parameter int ITAG_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lsu_wbck_i_valid,
    output logic                 lsu_wbck_i_ready,
    input  logic [XLEN-1:0]      lsu_wbck_i_wdat,
    input  logic [ITAG_W-1:0]    lsu_wbck_i_itag,
    input  logic                 lsu_wbck_i_err,
    input  logic                 lsu_cmt_i_buserr,
    input  logic                 lsu_cmt_i_ld,
    input  logic                 lsu_cmt_i_st,
    input  logic [ADDR_SIZE-1:0] lsu_cmt_i_badaddr,
    input  logic                 oitf_empty,
    input  logic [ITAG_W-1:0]    oitf_ret_ptr,
    input  logic [4:0]           oitf_ret_rdidx,
    input  logic                 oitf_ret_rdwen,
    input  logic [PC_SIZE-1:0]   oitf_ret_pc,
    output logic                 oitf_ret_ena,
    output logic                 longp_wbck_o_valid,
    input  logic                 longp_wbck_o_ready,
    output logic [XLEN-1:0]      longp_wbck_o_wdat,
    output logic [4:0]           longp_wbck_o_rdidx,
    output logic                 longp_excp_o_valid,
    input  logic                 longp_excp_o_ready,
    output logic                 longp_excp_o_ld,
    output logic                 longp_excp_o_st,
    output logic                 longp_excp_o_buserr,
    output logic                 longp_excp_o_insterr,
    output logic [ADDR_SIZE-1:0] longp_excp_o_badaddr,
    output logic [PC_SIZE-1:0]   longp_excp_o_pc
);
    typedef struct packed {
        logic                 excp;
        logic [XLEN-1:0]      wdat;
        logic [4:0]           rdidx;
        logic                 ld;
        logic                 st;
        logic                 buserr;
        logic [ADDR_SIZE-1:0] badaddr;
        logic [PC_SIZE-1:0]   pc;
    } pay_t;
    logic buf_vld_q, buf_vld_d;
    pay_t pay_q, pay_d;
    logic match, need_buf, drain, accept, capture;
    always_comb begin
        match            = lsu_wbck_i_valid & ~oitf_empty & (lsu_wbck_i_itag == oitf_ret_ptr);
        need_buf         = lsu_wbck_i_err | oitf_ret_rdwen;
        drain            = buf_vld_q & (pay_q.excp ? longp_excp_o_ready : longp_wbck_o_ready);
        lsu_wbck_i_ready = rst_n & match & (~need_buf | ~buf_vld_q | drain);
        accept           = lsu_wbck_i_valid & lsu_wbck_i_ready;
        capture          = accept & need_buf;
        buf_vld_d        = capture | (buf_vld_q & ~drain);
        pay_d            = capture ? '{excp: lsu_wbck_i_err, wdat: lsu_wbck_i_wdat, rdidx: oitf_ret_rdidx,
                                       ld: lsu_cmt_i_ld, st: lsu_cmt_i_st, buserr: lsu_cmt_i_buserr,
                                       badaddr: lsu_cmt_i_badaddr, pc: oitf_ret_pc} : pay_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld_q <= 1'b0;
            pay_q     <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            pay_q     <= pay_d;
        end
    end
    assign oitf_ret_ena         = accept;
    assign longp_wbck_o_valid   = buf_vld_q & ~pay_q.excp;
    assign longp_excp_o_valid   = buf_vld_q & pay_q.excp;
    assign longp_wbck_o_wdat    = pay_q.wdat;
    assign longp_wbck_o_rdidx   = pay_q.rdidx;
    assign longp_excp_o_ld      = pay_q.ld;
    assign longp_excp_o_st      = pay_q.st;
    assign longp_excp_o_buserr  = pay_q.buserr;
    assign longp_excp_o_insterr = 1'b0;
    assign longp_excp_o_badaddr = pay_q.badaddr;
    assign longp_excp_o_pc      = pay_q.pc;
endmodule
